// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, h/v counters, active-low syncs,
// visible-area flag and one-clk frame/vblank event pulses. All outputs registered.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLANK  = 10'(V_ACTIVE);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div, div_n;
  logic        adv;
  logic [9:0]  h_n, v_n;
  logic [10:0] hx, vx;

  always_comb begin
    adv   = (div == DIV_LAST);
    div_n = adv ? 4'd0 : div + 4'd1;
    h_n   = hcount;
    v_n   = vcount;
    if (adv) begin
      if (hcount < H_LAST) begin
        h_n = hcount + 10'd1;
      end else begin
        h_n = 10'd0;
        v_n = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end
    end
    hx = {1'b0, h_n};
    vx = {1'b0, v_n};
  end

  // Decodes use next-state counters so they line up with the registered counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div          <= 4'd0;
      hcount       <= 10'd0;
      vcount       <= 10'd0;
      pix_en       <= (CLK_DIV == 1);
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      bright       <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      div          <= div_n;
      hcount       <= h_n;
      vcount       <= v_n;
      pix_en       <= (div_n == DIV_LAST);
      hsync        <= !(hx >= HS_BEG && hx < HS_END);
      vsync        <= !(vx >= VS_BEG && vx < VS_END);
      bright       <= (hx < H_VIS) && (vx < V_VIS);
      frame_start  <= adv && (h_n == 10'd0) && (v_n == 10'd0);
      vblank_start <= adv && (h_n == 10'd0) && (v_n == V_BLANK);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets compared every cycle against an
// arithmetic model (position = elapsed clocks / CLK_DIV), plus literal timing checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs, vs, br, fs, vb;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  int   nvec = 0, nerr = 0, cyc = 0;
  int   t0 = 0, t1 = 0, t2 = 0;

  logic       pe0, pe1, pe2, hs0, hs1, hs2, vs0, vs1, vs2, br0, br1, br2;
  logic       fs0, fs1, fs2, vb0, vb1, vb2;
  logic [9:0] h0, h1, h2, v0, v1, v2;

  // u0: defaults; u1: small frame, CLK_DIV=3; u2: tiny frame, CLK_DIV=1
  vga_timing_gen u0 (.clk(clk), .reset(rst0), .pix_en(pe0), .hcount(h0), .vcount(v0),
    .hsync(hs0), .vsync(vs0), .bright(br0), .frame_start(fs0), .vblank_start(vb0));
  vga_timing_gen #(.H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5), .V_ACTIVE(12), .V_FP(2),
    .V_SYNC(3), .V_BP(4), .CLK_DIV(3)) u1 (.clk(clk), .reset(rst1), .pix_en(pe1),
    .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1), .bright(br1),
    .frame_start(fs1), .vblank_start(vb1));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(1)) u2 (.clk(clk), .reset(rst2), .pix_en(pe2),
    .hcount(h2), .vcount(v2), .hsync(hs2), .vsync(vs2), .bright(br2),
    .frame_start(fs2), .vblank_start(vb2));

  out_t o0, o1, o2;
  assign o0 = {pe0, h0, v0, hs0, vs0, br0, fs0, vb0};
  assign o1 = {pe1, h1, v1, hs1, vs1, br1, fs1, vb1};
  assign o2 = {pe2, h2, v2, hs2, vs2, br2, fs2, vb2};

  // t = rising edges since reset release; t/d pixels have elapsed.
  function automatic out_t model(input int ha, hf, hs, hb, va, vf, vs, vb, d, t);
    out_t o;
    int ht, vt, p, h, v;
    logic adv;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = t / d;
    h = p % ht;
    v = (p / ht) % vt;
    adv = (t > 0) && (t % d == 0);
    o.pe = (t % d == d - 1);
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = !(h >= ha + hf && h < ha + hf + hs);
    o.vs = !(v >= va + vf && v < va + vf + vs);
    o.br = (h < ha) && (v < va);
    o.fs = adv && h == 0 && v == 0;
    o.vb = adv && h == 0 && v == va;
    return o;
  endfunction

  always @(posedge clk) begin
    cyc++;
    t0 = rst0 ? 0 : t0 + 1;
    t1 = rst1 ? 0 : t1 + 1;
    t2 = rst2 ? 0 : t2 + 1;
  end

  task automatic cmp(input string nm, input out_t act, input out_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b vb=%b, expected pe=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b vb=%b",
        nm, cyc, act.pe, act.h, act.v, act.hs, act.vs, act.br, act.fs, act.vb,
        exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.fs, exp.vb);
    end
  endtask

  always @(negedge clk) begin
    cmp("u0_model", o0, model(640, 16, 96, 48, 480, 10, 2, 33, 2, t0));
    cmp("u1_model", o1, model(20, 4, 6, 5, 12, 2, 3, 4, 3, t1));
    cmp("u2_model", o2, model(8, 2, 2, 2, 4, 1, 1, 1, 1, t2));
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int c0, c1, cv, k;
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_h0", h0, 0);  chk("rst_v0", v0, 0);  chk("rst_pe0", pe0, 0);
    chk("rst_hs0", hs0, 1); chk("rst_vs0", vs0, 1); chk("rst_br0", br0, 1);
    chk("rst_fs0", fs0, 0); chk("rst_vb0", vb0, 0); chk("rst_pe2", pe2, 1);
    #1 rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // pix_en on alternate clocks, hcount=2 after 4 clocks
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("pe0_pattern", pe0, i % 2);
      if (i == 4) chk("h0_after4", h0, 2);
    end

    // horizontal window at defaults
    k = 0; while (h0 != 10'd640 && k < 4000) begin @(negedge clk); k++; end
    chk("h0_reach640", h0, 640);
    chk("bright_fall640", br0, 0);
    k = 0; while (h0 != 10'd656 && k < 4000) begin @(negedge clk); k++; end
    chk("h0_reach656", h0, 656);
    chk("hsync_fall656", hs0, 0);
    c0 = cyc;
    k = 0; while (h0 != 10'd752 && k < 4000) begin @(negedge clk); k++; end
    chk("hsync_rise752", hs0, 1);
    chk("hsync_low_clks", cyc - c0, 192);

    // frame and vblank timing on u1
    k = 0; while (!fs1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_fs_first", fs1, 1);
    c0 = cyc;
    @(negedge clk);
    chk("u1_fs_width", fs1, 0);
    k = 0; while (!vb1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_vb_seen", vb1, 1);
    chk("u1_vb_h", h1, 0);
    chk("u1_vb_v", v1, 12);
    cv = cyc;
    @(negedge clk);
    chk("u1_vb_width", vb1, 0);
    k = 0; while (vs1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_vsync_fall_v", v1, 14);
    c1 = cyc;
    k = 0; while (!vs1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_vsync_low_clks", cyc - c1, 315);
    k = 0; while (!fs1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_fs_second", fs1, 1);
    chk("u1_frame_clks", cyc - c0, 2205);
    chk("u1_vb_to_fs_clks", cyc - cv, 945);

    // CLK_DIV=1: wrap 13->0 and 98-clock frame
    k = 0; while (h2 != 10'd13 && k < 200) begin @(negedge clk); k++; end
    chk("u2_reach13", h2, 13);
    @(negedge clk);
    chk("u2_wrap0", h2, 0);
    k = 0; while (!fs2 && k < 200) begin @(negedge clk); k++; end
    c0 = cyc;
    @(negedge clk);
    k = 0; while (!fs2 && k < 200) begin @(negedge clk); k++; end
    chk("u2_fs_seen", fs2, 1);
    chk("u2_frame_clks", cyc - c0, 98);

    // asynchronous reset mid-frame on u1
    k = 0; while (!(v1 == 10'd9 && h1 == 10'd17) && k < 5000) begin @(negedge clk); k++; end
    chk("u1_reach_mid", v1, 9);
    #1 rst1 = 1'b1;
    #1;
    chk("async_h1", h1, 0); chk("async_v1", v1, 0); chk("async_pe1", pe1, 0);
    chk("async_br1", br1, 1); chk("async_hs1", hs1, 1);
    repeat (3) @(negedge clk);
    #1 rst1 = 1'b0;
    c0 = cyc;
    k = 0; while (!fs1 && k < 5000) begin @(negedge clk); k++; end
    chk("u1_fs_after_rst", fs1, 1);
    chk("u1_rst_to_fs_clks", cyc - c0, 2205);

    // randomized reset pulses; every cycle still checked against the model
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(4000, 30)) @(negedge clk);
      #1;
      case ($urandom_range(2, 0))
        0: rst0 = 1'b1;
        1: rst1 = 1'b1;
        default: rst2 = 1'b1;
      endcase
      repeat ($urandom_range(5, 1)) @(negedge clk);
      #1 rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    end
    repeat (2500) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
